// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller feeding a UART transmitter's start/data/busy handshake.
// Queues bus writes and hands them to the transmitter one at a time, reporting occupancy and overflow.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          tx_idle
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          push, pop, reject;

  always_comb begin
    // Full/empty come from the registered level, so a same-cycle pop never frees room
    // for a push and a freshly pushed byte never pops in the cycle it arrives.
    push   = wr_en & ~full_q & ~flush;
    reject = wr_en & full_q & ~flush;
    // A flush cycle launches nothing: the entry it would pop is being discarded.
    pop    = (state_q == IDLE) & ~empty_q & ~tx_busy & ~flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | reject;
    tx_start_d = pop;
    tx_data_d  = tx_data_q;
    state_d    = state_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    if (pop) tx_data_d = mem_q[rd_ptr_q];

    full_d  = (level_d == (AW+1)'(DEPTH));
    empty_d = (level_d == '0);

    case (state_q)
      IDLE:      if (pop) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign tx_idle  = empty_q & (state_q == IDLE) & ~tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter that stays busy for a fixed count.
// The transmitter is never reset, mirroring the real one sitting outside the reset domain.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int AW       = $clog2(DEPTH);
  localparam int BUSY_LEN = 10;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_idle;
  logic          busy_force;

  int            busy_cnt;
  int            n_starts;
  int            n_bad;
  logic [7:0]    sent [$];
  int            n_chk;
  int            n_err;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_idle  (tx_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign tx_busy = busy_force | (busy_cnt != 0);

  // Transmitter model: latches a byte on a start seen while not busy.
  initial begin
    busy_cnt = 0;
    n_starts = 0;
    n_bad    = 0;
  end

  always @(posedge clk) begin
    if (tx_start) begin
      n_starts = n_starts + 1;
      if (tx_busy) n_bad = n_bad + 1;
      else begin
        sent.push_back(tx_data);
        busy_cnt <= BUSY_LEN;
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i;
    for (i = 0; i < max && !tx_idle; i++) tick();
    chk(tag, tx_idle, 1'b1);
  endtask

  initial begin
    int base_s, base_q, mism, maxl, cyc, nxt;
    logic [7:0] v;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    busy_force = 1'b0;
    #2 rst_n = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom_range(0, 255));
      flush   = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_idle", tx_idle, 1);
    wr_en = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_no_start", n_starts, 0);

    // Single byte A5
    base_s = n_starts;
    base_q = sent.size();
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("single_level_after_push", level, 1);
    chk("single_start_edge1", tx_start, 0);
    tick();
    chk("single_start_edge2", tx_start, 1);
    chk("single_tx_data", tx_data, 8'hA5);
    chk("single_level_after_pop", level, 0);
    tick();
    chk("single_start_drop", tx_start, 0);
    wait_idle("single_idle", 40);
    chk("single_starts", n_starts - base_s, 1);
    chk("single_sent_n", sent.size() - base_q, 1);
    if (sent.size() > base_q) chk("single_sent_byte", sent[base_q], 8'hA5);

    // Burst of DEPTH+2 with busy held high
    busy_force = 1'b1;
    base_s = n_starts;
    base_q = sent.size();
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      if (i == DEPTH - 2) chk("burst_not_full_15", full, 0);
      if (i == DEPTH - 1) begin
        chk("burst_full", full, 1);
        chk("burst_level_full", level, DEPTH);
        chk("burst_no_ovf_yet", overflow, 0);
      end
    end
    wr_en = 1'b0;
    chk("burst_overflow", overflow, 1);
    chk("burst_level", level, DEPTH);
    chk("burst_no_start_busy", n_starts - base_s, 0);
    busy_force = 1'b0;
    wait_idle("burst_drain", 600);
    chk("burst_sent_n", sent.size() - base_q, DEPTH);
    chk("burst_starts", n_starts - base_s, DEPTH);
    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (sent.size() > base_q + i && sent[base_q + i] !== 8'(i)) mism++;
    chk("burst_order", mism, 0);
    chk("burst_ovf_sticky", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears_ovf", overflow, 0);

    // Wrap-around stream of 3*DEPTH bytes
    base_q = sent.size();
    nxt = 0;
    maxl = 0;
    cyc = 0;
    while ((sent.size() - base_q) < 3 * DEPTH && cyc < 3000) begin
      if (nxt < 3 * DEPTH && !full) begin
        wr_en = 1'b1;
        wr_data = 8'(nxt) ^ 8'h5A;
        nxt++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
      if (int'(level) > maxl) maxl = int'(level);
    end
    wr_en = 1'b0;
    wait_idle("wrap_idle", 40);
    chk("wrap_sent_n", sent.size() - base_q, 3 * DEPTH);
    mism = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      v = 8'(i) ^ 8'h5A;
      if (sent.size() > base_q + i && sent[base_q + i] !== v) mism++;
    end
    chk("wrap_order", mism, 0);
    chk("wrap_maxlevel_ok", maxl <= DEPTH, 1);
    chk("wrap_reached_full", maxl, DEPTH);
    chk("wrap_no_ovf", overflow, 0);

    // Flush during WAIT_DONE with 5 queued
    base_s = n_starts;
    base_q = sent.size();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("flush_pre_level", level, 5);
    chk("flush_pre_busy", tx_busy, 1);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_overflow", overflow, 0);
    chk("flush_tx_data_kept", tx_data, 8'h30);
    wait_idle("flush_inflight_done", 40);
    for (int i = 0; i < 20; i++) tick();
    chk("flush_starts", n_starts - base_s, 1);
    chk("flush_sent_n", sent.size() - base_q, 1);
    if (sent.size() > base_q) chk("flush_sent_byte", sent[base_q], 8'h30);

    // Async reset in WAIT_BUSY while transmitter busy
    wr_en = 1'b1;
    wr_data = 8'h41;
    tick();
    wr_data = 8'h42;
    tick();
    wr_en = 1'b0;
    tick();
    chk("arst_pre_busy", tx_busy, 1);
    chk("arst_pre_level", level, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_tx_start", tx_start, 0);
    chk("arst_tx_idle_busy", tx_idle, 0);
    tick();
    rst_n = 1'b1;
    base_s = n_starts;
    base_q = sent.size();
    wr_en = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tick();
    chk("arst_hold_while_busy", tx_start, 0);
    wait_idle("arst_idle", 60);
    chk("arst_starts", n_starts - base_s, 1);
    chk("arst_sent_n", sent.size() - base_q, 1);
    if (sent.size() > base_q) chk("arst_sent_byte", sent[base_q], 8'h77);
    chk("no_start_while_busy", n_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
